// File: rtl/branch_predict_unit.sv
// Branch resolution (EX) and bimodal 2-bit-counter prediction (IF) with a registered one-cycle mispredict flush.
// Optional statistics counters are compiled in with the macro BRANCH_PREDICT_STATS_EN.
module branch_predict_unit #(
   parameter int XLEN        = 32,
   parameter int BHT_ENTRIES = 64
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [XLEN-1:0] if_pc,
   output logic            pred_taken,
   input  logic            ex_valid,
   input  logic            ex_branch,
   input  logic [2:0]      ex_funct3,
   input  logic            Zflag,
   input  logic            Cflag,
   input  logic            Vflag,
   input  logic            Sflag,
   input  logic [XLEN-1:0] ex_pc,
   input  logic [XLEN-1:0] ex_target,
   input  logic            ex_pred_taken,
   output logic            branch_taken,
   output logic            flush,
   output logic [XLEN-1:0] redirect_pc
`ifdef BRANCH_PREDICT_STATS_EN
   ,
   output logic [31:0]     stat_branches,
   output logic [31:0]     stat_mispredicts
`endif
);

   // Derived; BHT_ENTRIES must be a power of two and at least 2.
   localparam int IDX_W = $clog2(BHT_ENTRIES);

   logic [1:0]       bht [BHT_ENTRIES];
   logic [IDX_W-1:0] if_idx;
   logic [IDX_W-1:0] ex_idx;
   logic             cond;
   logic             legal;
   logic             resolve;
   logic             mispredict;
   logic [XLEN-1:0]  next_pc;

   function automatic logic [1:0] sat_update(input logic [1:0] cnt, input logic up);
      logic [1:0] res;
      res = cnt;
      if (up && cnt != 2'b11) begin
         res = cnt + 2'b01;
      end else if (!up && cnt != 2'b00) begin
         res = cnt - 2'b01;
      end
      return res;
   endfunction

   assign if_idx = if_pc[IDX_W+1:2];
   assign ex_idx = ex_pc[IDX_W+1:2];

   // Asynchronous read: a same-cycle write to this index is seen only after the edge.
   assign pred_taken = bht[if_idx][1];

   always_comb begin
      cond  = 1'b0;
      legal = 1'b1;
      case (ex_funct3)
         3'b000:  cond = Zflag;
         3'b001:  cond = ~Zflag;
         3'b100:  cond = Sflag ^ Vflag;
         3'b101:  cond = ~(Sflag ^ Vflag);
         3'b110:  cond = ~Cflag;
         3'b111:  cond = Cflag;
         default: begin
            cond  = 1'b0;
            legal = 1'b0;
         end
      endcase
   end

   // The instruction in EX during a flush cycle is wrong-path and has no effect.
   assign branch_taken = cond & ex_branch & ex_valid & ~flush;
   assign resolve      = ex_valid & ex_branch & ~flush & legal;
   assign mispredict   = resolve & (branch_taken != ex_pred_taken);
   assign next_pc      = branch_taken ? ex_target : ex_pc + XLEN'(4);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < BHT_ENTRIES; i++) begin
            bht[i] <= 2'b01;
         end
      end else if (resolve) begin
         bht[ex_idx] <= sat_update(bht[ex_idx], branch_taken);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flush       <= 1'b0;
         redirect_pc <= '0;
      end else begin
         flush <= mispredict;
         if (resolve) begin
            redirect_pc <= next_pc;
         end
      end
   end

`ifdef BRANCH_PREDICT_STATS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_branches    <= '0;
         stat_mispredicts <= '0;
      end else if (resolve) begin
         stat_branches <= stat_branches + 32'd1;
         if (mispredict) begin
            stat_mispredicts <= stat_mispredicts + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_branch_predict_unit.sv
// Table-driven bench for branch_predict_unit: combinational outputs checked per vector,
// registered flush/redirect_pc checked one cycle later through an expected queue.
module tb_branch_predict_unit;

   localparam int XLEN = 32;

   logic            clk;
   logic            rst_n;
   logic [XLEN-1:0] if_pc;
   logic            pred_taken;
   logic            ex_valid;
   logic            ex_branch;
   logic [2:0]      ex_funct3;
   logic            Zflag, Cflag, Vflag, Sflag;
   logic [XLEN-1:0] ex_pc;
   logic [XLEN-1:0] ex_target;
   logic            ex_pred_taken;
   logic            branch_taken;
   logic            flush;
   logic [XLEN-1:0] redirect_pc;
`ifdef BRANCH_PREDICT_STATS_EN
   logic [31:0]     stat_branches;
   logic [31:0]     stat_mispredicts;
`endif

   branch_predict_unit #(.XLEN(XLEN), .BHT_ENTRIES(64)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .if_pc         (if_pc),
      .pred_taken    (pred_taken),
      .ex_valid      (ex_valid),
      .ex_branch     (ex_branch),
      .ex_funct3     (ex_funct3),
      .Zflag         (Zflag),
      .Cflag         (Cflag),
      .Vflag         (Vflag),
      .Sflag         (Sflag),
      .ex_pc         (ex_pc),
      .ex_target     (ex_target),
      .ex_pred_taken (ex_pred_taken),
      .branch_taken  (branch_taken),
      .flush         (flush),
      .redirect_pc   (redirect_pc)
`ifdef BRANCH_PREDICT_STATS_EN
      ,
      .stat_branches    (stat_branches),
      .stat_mispredicts (stat_mispredicts)
`endif
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish within time limit");
      $fatal(1, "timeout");
   end

   typedef struct {
      logic            valid;
      logic            branch;
      logic [2:0]      f3;
      logic            z, c, v, s;
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] tgt;
      logic            pred;
      logic            e_pred;
      logic            e_taken;
      logic            e_flush;
      logic [XLEN-1:0] e_redir;
   } vec_t;

   vec_t vecs[21];
   logic [XLEN:0] exp_q[$];
   int n_vec = 0;
   int n_err = 0;

   function automatic vec_t mk(input logic valid, input logic branch, input logic [2:0] f3,
                               input logic z, input logic c, input logic v, input logic s,
                               input logic [XLEN-1:0] pc, input logic [XLEN-1:0] tgt,
                               input logic pred, input logic e_pred, input logic e_taken,
                               input logic e_flush, input logic [XLEN-1:0] e_redir);
      vec_t r;
      r.valid = valid; r.branch = branch; r.f3 = f3;
      r.z = z; r.c = c; r.v = v; r.s = s;
      r.pc = pc; r.tgt = tgt; r.pred = pred;
      r.e_pred = e_pred; r.e_taken = e_taken; r.e_flush = e_flush; r.e_redir = e_redir;
      return r;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // driver tasks
   task automatic drive(input vec_t v);
      ex_valid      = v.valid;
      ex_branch     = v.branch;
      ex_funct3     = v.f3;
      Zflag         = v.z;
      Cflag         = v.c;
      Vflag         = v.v;
      Sflag         = v.s;
      ex_pc         = v.pc;
      ex_target     = v.tgt;
      ex_pred_taken = v.pred;
      if_pc         = v.pc;
   endtask

   task automatic apply(input vec_t v, input int id);
      drive(v);
      n_vec++;
      #1;
      check($sformatf("v%0d pred_taken", id), 64'(pred_taken), 64'(v.e_pred));
      check($sformatf("v%0d branch_taken", id), 64'(branch_taken), 64'(v.e_taken));
      exp_q.push_back({v.e_flush, v.e_redir});
   endtask

   // scoreboard: registered outputs compared the cycle after the vector
   task automatic check_regs();
      logic [XLEN:0] e;
      if (exp_q.size() == 0) return;
      e = exp_q.pop_front();
      check("flush", 64'(flush), 64'(e[XLEN]));
      check("redirect_pc", 64'(redirect_pc), 64'(e[XLEN-1:0]));
   endtask

   task automatic idle();
      drive(mk(0, 0, 3'b000, 0, 0, 0, 0, 32'h0, 32'h0, 0, 0, 0, 0, 32'h0));
   endtask

   initial begin
      vecs[0]  = mk(1, 1, 3'b000, 1, 0, 0, 0, 32'h100, 32'h200, 0,  0, 1, 1, 32'h200);
      vecs[1]  = mk(1, 1, 3'b001, 0, 0, 0, 0, 32'h100, 32'h300, 0,  1, 0, 0, 32'h200);
      vecs[2]  = mk(1, 1, 3'b000, 1, 0, 0, 0, 32'h100, 32'h200, 1,  1, 1, 0, 32'h200);
      vecs[3]  = mk(1, 1, 3'b000, 1, 0, 0, 0, 32'h100, 32'h200, 1,  1, 1, 0, 32'h200);
      vecs[4]  = mk(1, 1, 3'b001, 1, 0, 0, 0, 32'h100, 32'h300, 1,  1, 0, 1, 32'h104);
      vecs[5]  = mk(1, 1, 3'b000, 1, 0, 0, 0, 32'h100, 32'h200, 0,  1, 0, 0, 32'h104);
      vecs[6]  = mk(1, 1, 3'b001, 1, 0, 0, 0, 32'h100, 32'h300, 1,  1, 0, 1, 32'h104);
      vecs[7]  = mk(0, 0, 3'b000, 0, 0, 0, 0, 32'h100, 32'h0,   0,  0, 0, 0, 32'h104);
      vecs[8]  = mk(1, 1, 3'b100, 0, 0, 0, 1, 32'h40,  32'h104, 1,  0, 1, 0, 32'h104);
      vecs[9]  = mk(1, 1, 3'b111, 0, 0, 0, 0, 32'hFFFFFFFC, 32'h10, 1, 0, 0, 1, 32'h0);
      vecs[10] = mk(1, 1, 3'b101, 0, 0, 0, 0, 32'h40,  32'h500, 0,  1, 0, 0, 32'h0);
      vecs[11] = mk(1, 1, 3'b111, 0, 0, 0, 0, 32'hFFFFFFFC, 32'h10, 0, 0, 0, 0, 32'h0);
      vecs[12] = mk(1, 1, 3'b010, 1, 0, 0, 0, 32'h40,  32'h600, 1,  1, 0, 0, 32'h0);
      vecs[13] = mk(1, 1, 3'b011, 1, 1, 0, 0, 32'h40,  32'h600, 0,  1, 0, 0, 32'h0);
      vecs[14] = mk(0, 1, 3'b000, 1, 0, 0, 0, 32'h40,  32'h700, 0,  1, 0, 0, 32'h0);
      vecs[15] = mk(1, 1, 3'b110, 0, 0, 0, 0, 32'h40,  32'h1000, 1, 1, 1, 0, 32'h1000);
      vecs[16] = mk(1, 1, 3'b101, 0, 0, 1, 1, 32'h40,  32'h2000, 0, 1, 1, 1, 32'h2000);
      vecs[17] = mk(0, 0, 3'b000, 0, 0, 0, 0, 32'h40,  32'h0,   0,  1, 0, 0, 32'h2000);
      vecs[18] = mk(1, 1, 3'b100, 0, 0, 1, 1, 32'h40,  32'h3000, 0, 1, 0, 0, 32'h44);
      vecs[19] = mk(0, 0, 3'b000, 0, 0, 0, 0, 32'h40,  32'h0,   0,  1, 0, 0, 32'h44);
      vecs[20] = mk(0, 0, 3'b000, 0, 0, 0, 0, 32'hFFFFFFFC, 32'h0, 0, 0, 0, 0, 32'h44);

      rst_n = 1'b0;
      idle();
      if_pc = 32'h100;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset flush", 64'(flush), 64'd0);
      check("reset redirect_pc", 64'(redirect_pc), 64'd0);
      check("reset pred_taken", 64'(pred_taken), 64'd0);
      rst_n = 1'b1;

      for (int i = 0; i < 21; i++) begin
         @(negedge clk);
         check_regs();
         apply(vecs[i], i);
      end
      @(negedge clk);
      check_regs();
      check("queue drained", 64'(exp_q.size()), 64'd0);
`ifdef BRANCH_PREDICT_STATS_EN
      check("stat_branches", 64'(stat_branches), 64'd11);
      check("stat_mispredicts", 64'(stat_mispredicts), 64'd5);
`endif

      // asynchronous reset in the middle of a flush cycle
      drive(mk(1, 1, 3'b001, 1, 0, 0, 0, 32'h100, 32'h300, 1, 0, 0, 0, 32'h0));
      n_vec++;
      @(posedge clk);
      #2;
      check("pre-reset flush", 64'(flush), 64'd1);
      rst_n = 1'b0;
      #1;
      check("async reset flush", 64'(flush), 64'd0);
      check("async reset redirect_pc", 64'(redirect_pc), 64'd0);
`ifdef BRANCH_PREDICT_STATS_EN
      check("async reset stat_branches", 64'(stat_branches), 64'd0);
      check("async reset stat_mispredicts", 64'(stat_mispredicts), 64'd0);
`endif
      idle();
      if_pc = 32'h40;
      #1;
      check("reset pred 0x40", 64'(pred_taken), 64'd0);
      if_pc = 32'hFFFFFFFC;
      #1;
      check("reset pred 0xFFFFFFFC", 64'(pred_taken), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // one taken resolve from weakly-not-taken must flip the prediction
      drive(mk(1, 1, 3'b000, 1, 0, 0, 0, 32'h40, 32'h880, 0, 0, 0, 0, 32'h0));
      n_vec++;
      #1;
      check("post-reset branch_taken", 64'(branch_taken), 64'd1);
      @(negedge clk);
      idle();
      if_pc = 32'h40;
      #1;
      check("post-reset counter 01->10", 64'(pred_taken), 64'd1);
      check("post-reset flush", 64'(flush), 64'd1);
      check("post-reset redirect_pc", 64'(redirect_pc), 64'h880);
      @(negedge clk);
      check("flush one cycle", 64'(flush), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
